wb_buffer: RTL
==============

Name: wb_buffer

Overview:
- Write-back victim buffer between the dcache eviction path and the AXI write channel.
- Queues evicted dirty lines in FIFO order and drains them one at a time through the write channel's valid/addr/wdata/ready interface.
- Serves read lookups so a refill that hits a queued victim takes data from the buffer, not stale memory.
- Exposes `empty` for fences and uncached-ordering logic.

Parameters:
- ADDR_W, 32, byte address width.
- WORD_OFF_W, 3, log2 of words per line.
- FE_BYTE_W, 2, log2 of bytes per word.
- LINE_W, 256, line width in bits; must equal 32*2**WORD_OFF_W.
- DEPTH, 4, number of entries; power of two, ≥2.
- LA_W, ADDR_W-FE_BYTE_W-WORD_OFF_W, line-address width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; buffer is in reset while low.
- push_valid  in  1  eviction request from cache.
- push_addr  in  LA_W  line address of victim.
- push_data  in  LINE_W  victim line data.
- push_ready  out  1  buffer can accept; equals !full.
- lookup_valid  in  1  refill probe.
- lookup_addr  in  LA_W  probed line address.
- lookup_hit  out  1  combinational: valid entry matches.
- lookup_data  out  LINE_W  combinational: matching line; zero when no hit.
- wc_valid  out  1  start pulse to write channel.
- wc_addr  out  LA_W  head entry line address.
- wc_wdata  out  LINE_W  head entry data.
- wc_ready  in  1  write-channel completion strobe.
- empty  out  1  no valid entries.

Behaviour:
- Storage: circular FIFO with head/tail pointers of $clog2(DEPTH) bits and a count of $clog2(DEPTH)+1 bits.
- Push accepts on push_valid & push_ready: writes {addr,data} at tail, tail increments and wraps mod DEPTH.
- push_ready = (count != DEPTH). A pop in the same cycle does not make a full buffer accept.
- Drain FSM, states IDLE, ISSUE, WAIT:
  - IDLE: go to ISSUE when count != 0.
  - ISSUE: wc_valid=1 for exactly one cycle, then go to WAIT.
  - WAIT: wc_valid=0. On wc_ready=1, pop the head (head++, count--) and go to IDLE.
- wc_ready is ignored in IDLE and ISSUE. The write channel drives ready high while it is idle, so it is not a completion there.
- wc_addr and wc_wdata are driven from the head entry and stay stable from ISSUE until the pop. The head entry is never overwritten while draining.
- Minimum per-line overhead: 2 cycles (IDLE→ISSUE) before the write channel leaves idle.
- Simultaneous push and pop: both take effect and count is unchanged.
- Lookup: compares all valid entries, including the head under drain. When several entries match, the newest (closest to tail) wins. No state change; zero latency. Output is don't-care (driven 0) when lookup_valid=0.
- empty = (count == 0) & (state == IDLE).
- Reset (asynchronous, any state including mid-drain): pointers and count are 0, state is IDLE, wc_valid=0, push_ready=1, empty=1, lookup_hit=0, lookup_data=0. Entry data is not reset. An in-flight AXI burst is abandoned; the write channel is reset from the same tree.

Optional Feature:
- WB_BUF_MERGE_EN defined:
  - A push whose address matches a valid non-head entry, or matches the head while state==IDLE, overwrites that entry's data in place. No allocation.
  - push_ready is high on such a match even when full.
  - The match check uses the same comparator as lookup.
- WB_BUF_MERGE_EN undefined: every push allocates a new entry, and duplicate addresses are resolved by the newest-wins lookup.

Decomposition:
- Package wb_buffer_pkg:
  - wb_entry_t struct {logic [LA_W-1:0] line_addr; logic [LINE_W-1:0] data;}
  - wb_state_t enum {IDLE, ISSUE, WAIT}
  - pointer/count width localparams.
- One sub-module, wb_match_unit: takes the entry array, valid mask, head/tail and probe address. Returns hit, newest-match index and data. Instantiated once for lookup and, under WB_BUF_MERGE_EN, once for push merge.

Test Plan:
- Single push addr=0x0001234, data=line pattern 0xA5…; wc_ready pulse 10 cycles after ISSUE → one wc_valid pulse, wc_addr=0x0001234 stable until pop, empty=1 two cycles after pop.
- Push 4 lines with DEPTH=4, drain stalled → push_ready=0 after 4th accept; a 5th push is held. One completion → push_ready=1, 5th accepted. Drain order matches push order with wrap.
- wc_ready held 1 during IDLE and ISSUE (idle write-channel behaviour) → no pop. A single-cycle wc_ready in WAIT → exactly one pop.
- Two pushes of addr 0x40 with data D1 then D2, lookup 0x40 → lookup_hit=1, data=D2 (merge off). Merge on: count=1 and data=D2.
- Lookup of the head address while in WAIT → hit returns head data. After pop, the same lookup → hit=0, data=0.
- Assert reset low in WAIT with 3 entries → all outputs at reset values immediately. After release, no wc_valid until a new push.

Source files
------------

// File: rtl/wb_buffer_pkg.sv
// wb_buffer_pkg -- shared types and widths for the write-back victim buffer.
//
// Contents:
//   WB_* localparams   default geometry (32-bit byte address, 8 words/line,
//                      4 entries) and the derived pointer/count widths
//   wb_entry_t         one queued victim: line address plus line data
//   wb_state_t         drain FSM states
//   occupied_mask()    per-slot valid bits from head pointer and count
package wb_buffer_pkg;

    localparam int WB_ADDR_W     = 32;
    localparam int WB_WORD_OFF_W = 3;
    localparam int WB_FE_BYTE_W  = 2;
    localparam int WB_LINE_W     = 32 * (2 ** WB_WORD_OFF_W);
    localparam int WB_DEPTH      = 4;
    localparam int WB_LA_W       = WB_ADDR_W - WB_FE_BYTE_W - WB_WORD_OFF_W;
    localparam int WB_PTR_W      = $clog2(WB_DEPTH);
    localparam int WB_CNT_W      = WB_PTR_W + 1;

    typedef struct packed {
        logic [WB_LA_W-1:0]   line_addr;
        logic [WB_LINE_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } wb_state_t;

    // A slot is occupied when its distance from head (mod DEPTH) is below count.
    // The extra count bit distinguishes full from empty when head == tail.
    function automatic logic [WB_DEPTH-1:0] occupied_mask(
        input logic [WB_PTR_W-1:0] head,
        input logic [WB_CNT_W-1:0] count
    );
        logic [WB_DEPTH-1:0] m;
        m = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            m[i] = ({1'b0, WB_PTR_W'(i) - head} < count);
        end
        return m;
    endfunction

endpackage

// File: rtl/wb_match_unit.sv
// wb_match_unit -- associative address compare across the victim buffer.
//
// Ports:
//   entries  in   queued victims, indexed by slot
//   valid    in   per-slot valid mask (callers may mask out slots)
//   tail     in   next allocation slot; tail-1 is the newest entry
//   addr     in   probe line address
//   hit      out  some valid slot holds addr
//   idx      out  slot of the newest matching entry (0 when no hit)
//   data     out  data of the newest matching entry (0 when no hit)
module wb_match_unit
    import wb_buffer_pkg::*;
(
    input  wb_entry_t              entries [WB_DEPTH],
    input  logic [WB_DEPTH-1:0]    valid,
    input  logic [WB_PTR_W-1:0]    tail,
    input  logic [WB_LA_W-1:0]     addr,
    output logic                   hit,
    output logic [WB_PTR_W-1:0]    idx,
    output logic [WB_LINE_W-1:0]   data
);

    logic [WB_PTR_W-1:0] pos;

    // Walk from the oldest possible slot (tail-DEPTH) to the newest (tail-1);
    // later matches overwrite earlier ones so the newest entry wins.
    always_comb begin
        hit  = 1'b0;
        idx  = '0;
        data = '0;
        pos  = '0;
        for (int k = WB_DEPTH; k >= 1; k--) begin
            pos = tail - WB_PTR_W'(k);
            if (valid[pos] && (entries[pos].line_addr == addr)) begin
                hit  = 1'b1;
                idx  = pos;
                data = entries[pos].data;
            end
        end
    end

endmodule

// File: rtl/wb_buffer.sv
// wb_buffer -- write-back victim buffer between dcache eviction and the AXI
// write channel. Victims queue in FIFO order and drain one at a time; refill
// lookups are served from the buffer so stale memory is never returned.
//
// Optional feature: define WB_BUF_MERGE_EN to merge a push into an existing
// entry with the same line address (non-head, or head while not draining).
//
// Ports:
//   clk           in   clock
//   reset         in   asynchronous active-low reset
//   push_valid    in   eviction request
//   push_addr     in   victim line address
//   push_data     in   victim line data
//   push_ready    out  buffer can accept (not full, or merge target exists)
//   lookup_valid  in   refill probe
//   lookup_addr   in   probed line address
//   lookup_hit    out  probe matches a valid entry (combinational)
//   lookup_data   out  newest matching line, 0 on miss
//   wc_valid      out  one-cycle start pulse to the write channel
//   wc_addr       out  head entry line address
//   wc_wdata      out  head entry data
//   wc_ready      in   write-channel completion strobe (used only in WAIT)
//   empty         out  nothing queued and drain idle
//
// state | meaning
// IDLE  | no line in flight; leaves when an entry is queued
// ISSUE | wc_valid pulse for the head entry
// WAIT  | head in flight; wc_ready pops it
module wb_buffer
    import wb_buffer_pkg::*;
#(
    parameter int ADDR_W     = WB_ADDR_W,
    parameter int WORD_OFF_W = WB_WORD_OFF_W,
    parameter int FE_BYTE_W  = WB_FE_BYTE_W,
    parameter int LINE_W     = WB_LINE_W,
    parameter int DEPTH      = WB_DEPTH,
    parameter int LA_W       = ADDR_W - FE_BYTE_W - WORD_OFF_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_valid,
    input  logic [LA_W-1:0]   push_addr,
    input  logic [LINE_W-1:0] push_data,
    output logic              push_ready,
    input  logic              lookup_valid,
    input  logic [LA_W-1:0]   lookup_addr,
    output logic              lookup_hit,
    output logic [LINE_W-1:0] lookup_data,
    output logic              wc_valid,
    output logic [LA_W-1:0]   wc_addr,
    output logic [LINE_W-1:0] wc_wdata,
    input  logic              wc_ready,
    output logic              empty
);

    wb_entry_t            entries [WB_DEPTH];
    logic [WB_PTR_W-1:0]  head;
    logic [WB_PTR_W-1:0]  tail;
    logic [WB_CNT_W-1:0]  count;
    wb_state_t            state;
    wb_state_t            state_nxt;

    logic [WB_DEPTH-1:0]  valid_mask;
    logic                 full;
    logic                 pop;
    logic                 push_fire;
    logic                 push_alloc;
    logic                 push_merge;
    logic                 merge_hit;
    logic [WB_PTR_W-1:0]  merge_idx;

    logic                 lk_hit;
    logic [WB_PTR_W-1:0]  lk_idx;
    logic [WB_LINE_W-1:0] lk_data;
    logic                 unused_lk_idx;

    assign valid_mask = occupied_mask(head, count);
    assign full       = (count == WB_CNT_W'(DEPTH));

    wb_match_unit u_lookup (
        .entries (entries),
        .valid   (valid_mask),
        .tail    (tail),
        .addr    (lookup_addr),
        .hit     (lk_hit),
        .idx     (lk_idx),
        .data    (lk_data)
    );

    assign unused_lk_idx = ^lk_idx;
    assign lookup_hit    = lookup_valid & lk_hit;
    assign lookup_data   = (lookup_valid & lk_hit) ? lk_data : '0;

`ifdef WB_BUF_MERGE_EN
    logic [WB_DEPTH-1:0]  merge_mask;
    logic [WB_LINE_W-1:0] unused_mg_data;

    // The head is off limits once its drain has started: its data is already
    // committed to the write channel.
    always_comb begin
        merge_mask = valid_mask;
        if (state != IDLE) begin
            merge_mask[head] = 1'b0;
        end
    end

    wb_match_unit u_merge (
        .entries (entries),
        .valid   (merge_mask),
        .tail    (tail),
        .addr    (push_addr),
        .hit     (merge_hit),
        .idx     (merge_idx),
        .data    (unused_mg_data)
    );
`else
    assign merge_hit = 1'b0;
    assign merge_idx = '0;
`endif

    // A pop in the same cycle never frees space for a push while full.
    assign push_ready = ~full | merge_hit;
    assign push_fire  = push_valid & push_ready;
    assign push_alloc = push_fire & ~merge_hit;
    assign push_merge = push_fire & merge_hit;

    // Entry storage has no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_alloc) begin
            entries[tail] <= '{line_addr: push_addr, data: push_data};
        end else if (push_merge) begin
            entries[merge_idx].data <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_alloc) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push_alloc, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (count != '0) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (wc_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // wc_ready is a completion only in WAIT; an idle write channel holds it high.
    always_comb begin
        wc_valid = 1'b0;
        pop      = 1'b0;
        case (state)
            ISSUE:   wc_valid = 1'b1;
            WAIT:    pop = wc_ready;
            default: begin
                wc_valid = 1'b0;
                pop      = 1'b0;
            end
        endcase
    end

    assign wc_addr  = entries[head].line_addr;
    assign wc_wdata = entries[head].data;
    assign empty    = (count == '0) && (state == IDLE);

endmodule
